// File: rtl/daphne_iir_integrator_mc_pkg.sv
// Shared definitions for the DAPHNE multi-channel IIR integrator:
// the channel-index width helper, the Q-format rounding constant and the
// round/saturate helpers used by the datapath.
package daphne_filt_pkg;

    // Width of the per-channel saturation counters (optional feature)
    localparam int unsigned SatCntW = 16;

    // Channel index width; a single channel still gets a 1-bit index
    function automatic int unsigned chw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Value 0.5 in signed Q1.(cw-1)
    function automatic longint q_half(input int unsigned cw);
        return 64'sd1 <<< (cw - 2);
    endfunction

    // Round half up, then arithmetic shift right by sh (sh >= 1)
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] v,
                                                     input int unsigned sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    // Clamp v into a w-bit signed range; clip reports whether clamping happened
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned w,
                                                 output logic clip);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        r    = v;
        clip = 1'b0;
        if (v > hi) begin
            r    = hi;
            clip = 1'b1;
        end else if (v < lo) begin
            r    = lo;
            clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/daphne_iir_integrator_mc_if.sv
// Sample stream interface of the multi-channel IIR integrator.
// slave: the filter side (consumes s_*, produces m_*).
// master: the surrounding logic (produces s_*, consumes m_*).
interface daphne_iir_integrator_mc_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 16
);
    localparam int unsigned CHW = daphne_filt_pkg::chw(NCH);

    logic                 s_valid;
    logic                 s_ready;
    logic [CHW-1:0]       s_chan;
    logic signed [DW-1:0] s_data;
    logic                 m_valid;
    logic [CHW-1:0]       m_chan;
    logic signed [DW-1:0] m_data;
    logic                 m_sat;

    modport master (
        output s_valid, s_chan, s_data,
        input  s_ready, m_valid, m_chan, m_data, m_sat
    );

    modport slave (
        input  s_valid, s_chan, s_data,
        output s_ready, m_valid, m_chan, m_data, m_sat
    );

endinterface

// File: rtl/daphne_iir_mac.sv
// Stateless 3-stage datapath of the IIR integrator:
//   stage 2: products b0*x + b1*x_prev and a1*y_state
//   stage 3: accumulate, round to the y_state format, saturate
//   output : round to the sample format, saturate, or bypass the raw sample
// Channel, enable and writeback flags travel alongside the data.
module daphne_iir_mac
    import daphne_filt_pkg::*;
#(
    parameter int unsigned CHW = 3,
    parameter int unsigned DW  = 16,
    parameter int unsigned CW  = 18,
    parameter int unsigned YF  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    kill_wb,
    input  logic                    in_valid,
    input  logic [CHW-1:0]          in_chan,
    input  logic                    in_en,
    input  logic                    in_wb,
    input  logic signed [DW-1:0]    in_x,
    input  logic signed [DW-1:0]    in_xp,
    input  logic signed [DW+YF-1:0] in_y,
    input  logic signed [CW-1:0]    in_b0,
    input  logic signed [CW-1:0]    in_b1,
    input  logic signed [CW-1:0]    in_a1,
    output logic                    s2_valid,
    output logic [CHW-1:0]          s2_chan,
    output logic                    s3_valid,
    output logic [CHW-1:0]          s3_chan,
    output logic                    s3_wb,
    output logic signed [DW-1:0]    s3_x,
    output logic signed [DW+YF-1:0] s3_y,
    output logic                    out_valid,
    output logic [CHW-1:0]          out_chan,
    output logic signed [DW-1:0]    out_data,
    output logic                    out_sat
);
    localparam int unsigned YW  = DW + YF;
    localparam int unsigned PW0 = CW + DW + 1;
    localparam int unsigned PW1 = CW + DW + YF;
    localparam int unsigned AW  = CW + DW + YF + 2;

    logic                    s2_en, s2_wb;
    logic signed [DW-1:0]    s2_x;
    logic signed [PW0-1:0]   s2_p0;
    logic signed [PW1-1:0]   s2_p1;
    logic                    s3_en, s3_sat_y;

    logic signed [PW0-1:0]   p0_d;
    logic signed [PW1-1:0]   p1_d;
    logic signed [AW-1:0]    acc;
    logic signed [63:0]      y_full;
    logic signed [YW-1:0]    y_d;
    logic                    clip_y;
    logic signed [63:0]      o_full;
    logic                    clip_o;
    logic signed [DW-1:0]    data_d;
    logic                    sat_d;

    // Multiplier stage operands
    always_comb begin
        p0_d = PW0'(in_b0) * PW0'(in_x) + PW0'(in_b1) * PW0'(in_xp);
        p1_d = PW1'(in_a1) * PW1'(in_y);
    end

    // Stage 2 register: products and sidebands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_chan  <= '0;
            s2_en    <= 1'b0;
            s2_wb    <= 1'b0;
            s2_x     <= '0;
            s2_p0    <= '0;
            s2_p1    <= '0;
        end else begin
            s2_valid <= in_valid;
            s2_chan  <= in_chan;
            s2_en    <= in_en;
            s2_wb    <= in_wb & ~kill_wb;
            s2_x     <= in_x;
            s2_p0    <= p0_d;
            s2_p1    <= p1_d;
        end
    end

    // Accumulate in full precision, then round into the y_state format
    always_comb begin
        acc    = (AW'(s2_p0) <<< YF) + AW'(s2_p1);
        y_full = sat_s(round_shr(64'(acc), CW - 1), YW, clip_y);
        y_d    = YW'(y_full);
    end

    // Stage 3 register: new state value, also the forwarding/writeback source
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            s3_chan  <= '0;
            s3_en    <= 1'b0;
            s3_wb    <= 1'b0;
            s3_x     <= '0;
            s3_y     <= '0;
            s3_sat_y <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            s3_chan  <= s2_chan;
            s3_en    <= s2_en;
            s3_wb    <= s2_wb & ~kill_wb;
            s3_x     <= s2_x;
            s3_y     <= y_d;
            s3_sat_y <= clip_y;
        end
    end

    // Output rounding/saturation, or raw sample when bypassed
    always_comb begin
        o_full = sat_s(round_shr(64'(s3_y), YF), DW, clip_o);
        data_d = s3_en ? DW'(o_full) : s3_x;
        sat_d  = s3_en & (s3_sat_y | clip_o);
    end

    // Output register: single-cycle strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s3_valid;
            out_chan  <= s3_chan;
            out_data  <= data_d;
            out_sat   <= s3_valid & sat_d;
        end
    end

endmodule

// File: rtl/daphne_iir_integrator_mc.sv
// Multi-channel time-multiplexed first-order IIR integrator:
//   y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1]
// Holds per-channel x_prev/y_state, the same-channel interlock, stage-3
// forwarding and (with DAPHNE_IIR_SATCNT_EN defined) per-channel
// saturation counters with a registered read port.
module daphne_iir_integrator_mc
    import daphne_filt_pkg::*;
#(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 16,
    parameter int unsigned CW  = 18,
    parameter int unsigned YF  = 8,
    localparam int unsigned CHW = chw(NCH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic signed [CW-1:0]  coef_b0,
    input  logic signed [CW-1:0]  coef_b1,
    input  logic signed [CW-1:0]  coef_a1,
    daphne_iir_integrator_mc_if.slave bus
`ifdef DAPHNE_IIR_SATCNT_EN
    ,
    input  logic [CHW-1:0]        satcnt_sel,
    output logic [SatCntW-1:0]    satcnt
`endif
);
    localparam int unsigned YW = DW + YF;

    logic                 run_q;
    logic                 hazard, fwd, accept;
    logic signed [YW-1:0] rd_y;
    logic signed [DW-1:0] rd_x;

    logic signed [YW-1:0] y_state [NCH];
    logic signed [DW-1:0] x_prev  [NCH];

    logic                 s1_valid, s1_en, s1_wb;
    logic [CHW-1:0]       s1_chan;
    logic signed [DW-1:0] s1_x, s1_xp;
    logic signed [YW-1:0] s1_y;
    logic signed [CW-1:0] s1_b0, s1_b1, s1_a1;

    logic                 s2_valid, s3_valid, s3_wb;
    logic [CHW-1:0]       s2_chan, s3_chan;
    logic signed [DW-1:0] s3_x;
    logic signed [YW-1:0] s3_y;

    logic                 out_valid, out_sat;
    logic [CHW-1:0]       out_chan;
    logic signed [DW-1:0] out_data;

    // Holds s_ready low from reset assertion until the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    // Interlock against stages 1/2; stage 3 result is forwarded instead
    always_comb begin
        hazard = (s1_valid && (s1_chan == bus.s_chan)) ||
                 (s2_valid && (s2_chan == bus.s_chan));
        fwd    = s3_valid && s3_wb && (s3_chan == bus.s_chan);
        rd_y   = fwd ? s3_y : y_state[bus.s_chan];
        rd_x   = fwd ? s3_x : x_prev[bus.s_chan];
        accept = bus.s_valid && run_q && !hazard;
    end

    assign bus.s_ready = run_q & ~hazard;

    // Stage 1: capture sample, channel state and coefficients at acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            s1_en    <= 1'b0;
            s1_wb    <= 1'b0;
            s1_x     <= '0;
            s1_xp    <= '0;
            s1_y     <= '0;
            s1_b0    <= '0;
            s1_b1    <= '0;
            s1_a1    <= '0;
        end else begin
            s1_valid <= accept;
            // a clear on the acceptance edge also cancels this sample's writeback
            s1_wb    <= accept ? (enable & ~clear) : (s1_wb & ~clear);
            if (accept) begin
                s1_chan <= bus.s_chan;
                s1_en   <= enable;
                s1_x    <= bus.s_data;
                s1_xp   <= rd_x;
                s1_y    <= rd_y;
                s1_b0   <= coef_b0;
                s1_b1   <= coef_b1;
                s1_a1   <= coef_a1;
            end
        end
    end

    // Channel state: clear wins over a same-cycle writeback
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                y_state[i] <= '0;
                x_prev[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(NCH); i++) begin
                y_state[i] <= '0;
                x_prev[i]  <= '0;
            end
        end else if (s3_valid && s3_wb) begin
            y_state[s3_chan] <= s3_y;
            x_prev[s3_chan]  <= s3_x;
        end
    end

    daphne_iir_mac #(
        .CHW (CHW),
        .DW  (DW),
        .CW  (CW),
        .YF  (YF)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .kill_wb   (clear),
        .in_valid  (s1_valid),
        .in_chan   (s1_chan),
        .in_en     (s1_en),
        .in_wb     (s1_wb),
        .in_x      (s1_x),
        .in_xp     (s1_xp),
        .in_y      (s1_y),
        .in_b0     (s1_b0),
        .in_b1     (s1_b1),
        .in_a1     (s1_a1),
        .s2_valid  (s2_valid),
        .s2_chan   (s2_chan),
        .s3_valid  (s3_valid),
        .s3_chan   (s3_chan),
        .s3_wb     (s3_wb),
        .s3_x      (s3_x),
        .s3_y      (s3_y),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    assign bus.m_valid = out_valid;
    assign bus.m_chan  = out_chan;
    assign bus.m_data  = out_data;
    assign bus.m_sat   = out_sat;

`ifdef DAPHNE_IIR_SATCNT_EN
    logic [SatCntW-1:0] satcnt_q [NCH];

    // Per-channel saturation counters, sticky at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NCH); i++) satcnt_q[i] <= '0;
            satcnt <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < int'(NCH); i++) satcnt_q[i] <= '0;
            end else if (out_valid && out_sat && (satcnt_q[out_chan] != '1)) begin
                satcnt_q[out_chan] <= satcnt_q[out_chan] + 1'b1;
            end
            satcnt <= satcnt_q[satcnt_sel];
        end
    end
`endif

endmodule

// File: tb/tb_daphne_iir_integrator_mc.sv
// Directed self-checking bench for daphne_iir_integrator_mc.
module tb_daphne_iir_integrator_mc;

    logic               clk;
    logic               reset_n;
    logic               enable;
    logic               clear;
    logic signed [17:0] coef_b0, coef_b1, coef_a1;
`ifdef DAPHNE_IIR_SATCNT_EN
    logic [2:0]         satcnt_sel;
    logic [15:0]        satcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    daphne_iir_integrator_mc_if #(.NCH(8), .DW(16)) bus ();

    daphne_iir_integrator_mc #(
        .NCH (8),
        .DW  (16),
        .CW  (18),
        .YF  (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .coef_b0 (coef_b0),
        .coef_b1 (coef_b1),
        .coef_a1 (coef_a1),
        .bus     (bus)
`ifdef DAPHNE_IIR_SATCNT_EN
        ,
        .satcnt_sel (satcnt_sel),
        .satcnt     (satcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample, wait (bounded) for s_ready, return just after the accepting edge
    task automatic accept(input int ch, input int x, output int stalls);
        int k;
        k = 0;
        bus.s_valid = 1'b1;
        bus.s_chan  = 3'(ch);
        bus.s_data  = 16'(x);
        #1;
        while (bus.s_ready !== 1'b1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        stalls = k;
        if (k == 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: ch %0d s_ready=%b after 10 cycles, required 1", ch,
                     bus.s_ready);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({bus.s_ready, bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b v=%b ch=%0d d=%0d s=%b, required all 0",
                     bus.s_ready, bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b v=%b, required rdy=1 v=0",
                     bus.s_ready, bus.m_valid);
        end
    endtask

    task automatic test_gain();
        int st;
        coef_b0 = 18'sd65536;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd0;
        enable  = 1'b1;
        accept(0, 1000, st);
        tick();
        tick();
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gain_early: m_valid=%b at t+2, required 0", bus.m_valid);
        end
        tick();
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !== {1'b1, 3'd0, 16'(500), 1'b0})
        begin
            n_fail++;
            $display("FAIL gain_out: v=%b ch=%0d d=%0d s=%b, required v=1 ch=0 d=500 s=0",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat);
        end
        tick();
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gain_strobe: m_valid=%b one cycle later, required 0", bus.m_valid);
        end
    endtask

    // Same channel every 3 cycles exercises the stage-3 forwarding path
    task automatic test_integrate();
        int st;
        int exp_v[6];
        exp_v = '{500, 750, 875, 938, 969, 984};
        coef_b0 = 18'sd65536;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd65536;
        for (int n = 0; n <= 6; n++) begin
            if (n < 6) accept(3, 1000, st);
            else       tick();
            if (n > 0) begin
                n_checks++;
                if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !==
                    {1'b1, 3'd3, 16'(exp_v[n-1]), 1'b0}) begin
                    n_fail++;
                    $display("FAIL integ_out%0d: v=%b ch=%0d d=%0d s=%b, required v=1 ch=3 d=%0d s=0",
                             n - 1, bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat,
                             exp_v[n-1]);
                end
            end
            if (n < 6) begin
                tick();
                tick();
            end
        end
        accept(4, 0, st);
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !== {1'b1, 3'd4, 16'(0), 1'b0})
        begin
            n_fail++;
            $display("FAIL integ_other_ch: v=%b ch=%0d d=%0d, required v=1 ch=4 d=0",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data));
        end
    endtask

    task automatic test_saturation();
        int st;
        int exp_d[6];
        bit exp_s[6];
        int chs[6];
        int xs[6];
        exp_d = '{32767, 32767, 32767, -32768, -32768, -32768};
        exp_s = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        chs   = '{5, 5, 5, 6, 6, 6};
        xs    = '{32767, 32767, 32767, -32768, -32768, -32768};
        coef_b0 = 18'sd131071;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd131071;
        for (int n = 0; n < 6; n++) begin
            accept(chs[n], xs[n], st);
            tick();
            tick();
            tick();
            n_checks++;
            if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !==
                {1'b1, 3'(chs[n]), 16'(exp_d[n]), exp_s[n]}) begin
                n_fail++;
                $display("FAIL sat_out%0d: v=%b ch=%0d d=%0d s=%b, required v=1 ch=%0d d=%0d s=%0d",
                         n, bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat, chs[n],
                         exp_d[n], exp_s[n]);
            end
        end
    endtask

    task automatic test_interlock();
        logic [2:0] rdy_seq;
        coef_b0 = 18'sd65536;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd0;
        bus.s_valid = 1'b1;
        bus.s_chan  = 3'd2;
        bus.s_data  = 16'sd100;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_first_ready: s_ready=%b, required 1", bus.s_ready);
        end
        tick();
        bus.s_data = 16'sd200;
        rdy_seq[0] = bus.s_ready;
        tick();
        rdy_seq[1] = bus.s_ready;
        tick();
        rdy_seq[2] = bus.s_ready;
        n_checks++;
        if (rdy_seq !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_ready_seq: s_ready t+0..t+2=%b%b%b, required 001",
                     rdy_seq[0], rdy_seq[1], rdy_seq[2]);
        end
        tick();
        bus.s_valid = 1'b0;
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data} !== {1'b1, 3'd2, 16'(50)}) begin
            n_fail++;
            $display("FAIL lock_out0: v=%b ch=%0d d=%0d, required v=1 ch=2 d=50",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data));
        end
        tick();
        tick();
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_gap: m_valid=%b at t+5, required 0", bus.m_valid);
        end
        tick();
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data} !== {1'b1, 3'd2, 16'(100)}) begin
            n_fail++;
            $display("FAIL lock_out1: v=%b ch=%0d d=%0d at t+6, required v=1 ch=2 d=100",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data));
        end
    endtask

    task automatic test_back_to_back();
        int st;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                accept(c, (c + 1) * 20, st);
                n_checks++;
                if (st != 0) begin
                    n_fail++;
                    $display("FAIL rr_stall%0d: %0d stall cycles, required 0", c, st);
                end
            end else begin
                tick();
            end
            n_checks++;
            if (c >= 3) begin
                if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !==
                    {1'b1, 3'(c - 3), 16'((c - 2) * 10), 1'b0}) begin
                    n_fail++;
                    $display("FAIL rr_out%0d: v=%b ch=%0d d=%0d s=%b, required v=1 ch=%0d d=%0d s=0",
                             c - 3, bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat,
                             c - 3, (c - 2) * 10);
                end
            end else if (bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: m_valid=%b, required 0", c, bus.m_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int st;
        bit stale;
        coef_b0 = 18'sd65536;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd65536;
        for (int c = 0; c < 4; c++) accept(c, 1000, st);
        n_checks++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_valid: m_valid=%b before reset, required 1", bus.m_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: v=%b rdy=%b during reset, required 0 0",
                     bus.m_valid, bus.s_ready);
        end
        tick();
        tick();
        reset_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.m_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL rst_stale: m_valid seen=1 after reset, required 0");
        end
        accept(1, 1000, st);
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data} !== {1'b1, 3'd1, 16'(500)}) begin
            n_fail++;
            $display("FAIL rst_after: v=%b ch=%0d d=%0d, required v=1 ch=1 d=500",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data));
        end
    endtask

    task automatic test_clear_bypass();
        int st;
        int exp_v[7];
        int xs[7];
        int chs[7];
        bit ens[7];
        bit clr_pre[7];
        bit clr_mid[7];
        // build ch3 (500,750,875), clear, 500, bypass -1234, 750, then ch4 with in-flight clear
        exp_v   = '{500, 750, 875, 500, -1234, 750, 500};
        xs      = '{1000, 1000, 1000, 1000, -1234, 1000, 1000};
        chs     = '{3, 3, 3, 3, 3, 3, 4};
        ens     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        clr_pre = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        clr_mid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        coef_b0 = 18'sd65536;
        coef_b1 = 18'sd0;
        coef_a1 = 18'sd65536;
        for (int n = 0; n < 7; n++) begin
            if (clr_pre[n]) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            enable = ens[n];
            accept(chs[n], xs[n], st);
            enable = 1'b1;
            clear  = clr_mid[n];
            tick();
            clear  = 1'b0;
            tick();
            tick();
            n_checks++;
            if ({bus.m_valid, bus.m_chan, bus.m_data, bus.m_sat} !==
                {1'b1, 3'(chs[n]), 16'(exp_v[n]), 1'b0}) begin
                n_fail++;
                $display("FAIL clr_out%0d: v=%b ch=%0d d=%0d s=%b, required v=1 ch=%0d d=%0d s=0",
                         n, bus.m_valid, bus.m_chan, $signed(bus.m_data), bus.m_sat, chs[n],
                         exp_v[n]);
            end
        end
        // ch4 writeback was cancelled by the in-flight clear, so state is still zero
        accept(4, 1000, st);
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.m_valid, bus.m_chan, bus.m_data} !== {1'b1, 3'd4, 16'(500)}) begin
            n_fail++;
            $display("FAIL clr_inflight_wb: v=%b ch=%0d d=%0d, required v=1 ch=4 d=500",
                     bus.m_valid, bus.m_chan, $signed(bus.m_data));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        clear       = 1'b0;
        coef_b0     = '0;
        coef_b1     = '0;
        coef_a1     = '0;
        bus.s_valid = 1'b0;
        bus.s_chan  = '0;
        bus.s_data  = '0;
`ifdef DAPHNE_IIR_SATCNT_EN
        satcnt_sel  = '0;
`endif
        test_reset();
        test_gain();
        test_integrate();
        test_saturation();
        test_interlock();
        test_back_to_back();
        test_reset_midstream();
        test_clear_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
